// File: rtl/sysref_gen.sv
// SYSREF pulse-train generator: CSR-configured period/high width, continuous and burst modes.
// Optional macro SYSREF_GEN_TRIGGER_EN adds mode 3 (triggered burst) and the ARMED state.
//
//   state | meaning
//   IDLE  | no pulse train, waiting for a command write
//   ARMED | triggered-burst mode, waiting for trigger (only with SYSREF_GEN_TRIGGER_EN)
//   HIGH  | phase 0..H-1 of a period, sysrefOut high
//   LOW   | phase H..P-1 of a period, sysrefOut low
module sysref_gen #(
    parameter int    COUNTER_WIDTH = 8,
    parameter string DEBUG         = "false"
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csrStrobe,
    input  logic [31:0] GPIO_OUT,
    input  logic        trigger,
    output logic [31:0] statusReg,
    output logic        sysrefOut,
    output logic        sysrefActive
);
    localparam int            CW       = COUNTER_WIDTH;
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] TWO      = CW'(2);
    localparam logic [CW-1:0] RST_PER  = CW'(16);
    localparam logic [CW-1:0] RST_HIGH = CW'(8);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_HIGH, S_LOW} state_t;

    (* mark_debug = DEBUG *) state_t        state_q;
    state_t                                 state_d;
    (* mark_debug = DEBUG *) logic [CW-1:0] phase_q;
    (* mark_debug = DEBUG *) logic          sysref_q;
    (* mark_debug = DEBUG *) logic          active_q;
    logic                                   sysref_d, active_d;
    logic [CW-1:0] per_q, high_q, pend_per_q, pend_high_q;
    logic [1:0]    mode_q, pend_mode_q;
    logic [3:0]    pend_burst_q, rem_q;
    logic [15:0]   total_q;
    logic          new_cmd_q;

    logic          cfg_wr, cmd_wr, eff_new, period_end;
    logic [1:0]    cmd_mode, eff_mode;
    logic [3:0]    eff_burst;
    logic [CW-1:0] raw_per, raw_high, cfg_per, cfg_high, eff_per, eff_high;
    logic          launch, pulse_start, burst_load, rem_dec;

    // A write in the same cycle as a period boundary already counts for the next period.
    always_comb begin
        cfg_wr   = csrStrobe & GPIO_OUT[31];
        cmd_wr   = csrStrobe & ~GPIO_OUT[31];
`ifdef SYSREF_GEN_TRIGGER_EN
        cmd_mode = GPIO_OUT[29:28];
`else
        cmd_mode = (GPIO_OUT[29:28] == 2'd3) ? 2'd0 : GPIO_OUT[29:28];
`endif
        raw_per  = GPIO_OUT[0 +: CW];
        raw_high = GPIO_OUT[16 +: CW];
        cfg_per  = (raw_per < TWO) ? TWO : raw_per;
        if (raw_high == '0)            cfg_high = ONE;
        else if (raw_high >= cfg_per)  cfg_high = cfg_per - ONE;
        else                           cfg_high = raw_high;
        eff_per    = cfg_wr ? cfg_per  : pend_per_q;
        eff_high   = cfg_wr ? cfg_high : pend_high_q;
        eff_mode   = cmd_wr ? cmd_mode : pend_mode_q;
        eff_burst  = cmd_wr ? GPIO_OUT[27:24] : pend_burst_q;
        eff_new    = cmd_wr | new_cmd_q;
        period_end = (phase_q == per_q - ONE);
    end

    always_comb begin
        state_d     = state_q;
        launch      = 1'b0;
        pulse_start = 1'b0;
        burst_load  = 1'b0;
        rem_dec     = 1'b0;
        case (state_q)
            S_IDLE: launch = cmd_wr;
`ifdef SYSREF_GEN_TRIGGER_EN
            S_ARMED: begin
                if (cmd_wr) begin
                    launch = 1'b1;
                end else if (trigger && !csrStrobe) begin
                    state_d     = S_HIGH;
                    pulse_start = 1'b1;
                    burst_load  = 1'b1;
                end
            end
`endif
            S_HIGH, S_LOW: begin
                if (period_end) begin
                    if (eff_new) begin
                        launch = 1'b1;
                    end else if (mode_q == 2'd1) begin
                        state_d     = S_HIGH;
                        pulse_start = 1'b1;
                    end else if (rem_q != 4'd0) begin
                        state_d     = S_HIGH;
                        pulse_start = 1'b1;
                        rem_dec     = 1'b1;
`ifdef SYSREF_GEN_TRIGGER_EN
                    end else if (mode_q == 2'd3) begin
                        state_d = S_ARMED;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = (phase_q + ONE < high_q) ? S_HIGH : S_LOW;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (launch) begin
            case (eff_mode)
                2'd1: begin
                    state_d     = S_HIGH;
                    pulse_start = 1'b1;
                end
                2'd2: begin
                    state_d     = S_HIGH;
                    pulse_start = 1'b1;
                    burst_load  = 1'b1;
                end
`ifdef SYSREF_GEN_TRIGGER_EN
                2'd3: state_d = S_ARMED;
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        sysref_d = (state_d == S_HIGH);
        active_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sysref_q <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sysref_q <= sysref_d;
            active_q <= active_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q      <= '0;
            per_q        <= RST_PER;
            high_q       <= RST_HIGH;
            pend_per_q   <= RST_PER;
            pend_high_q  <= RST_HIGH;
            mode_q       <= 2'd0;
            pend_mode_q  <= 2'd0;
            pend_burst_q <= 4'd0;
            rem_q        <= 4'd0;
            total_q      <= 16'd0;
            new_cmd_q    <= 1'b0;
        end else begin
            if (cfg_wr) begin
                pend_per_q  <= cfg_per;
                pend_high_q <= cfg_high;
            end
            if (cmd_wr) begin
                pend_mode_q  <= cmd_mode;
                pend_burst_q <= GPIO_OUT[27:24];
            end
            new_cmd_q <= launch ? 1'b0 : (new_cmd_q | cmd_wr);
            if (launch) mode_q <= eff_mode;
            // Burst count 0 encodes 16; the first pulse starts on the load edge, hence the -1.
            if (burst_load)   rem_q <= eff_burst - 4'd1;
            else if (launch)  rem_q <= 4'd0;
            else if (rem_dec) rem_q <= rem_q - 4'd1;
            if (pulse_start) begin
                phase_q <= '0;
                per_q   <= eff_per;
                high_q  <= eff_high;
                total_q <= total_q + 16'd1;
            end else if (state_q == S_HIGH || state_q == S_LOW) begin
                phase_q <= phase_q + ONE;
            end
        end
    end

    assign sysrefOut    = sysref_q;
    assign sysrefActive = active_q;
    assign statusReg    = {active_q, 1'b0, mode_q, rem_q, 8'h00, total_q};

    logic unused_ok;
`ifdef SYSREF_GEN_TRIGGER_EN
    assign unused_ok = ^GPIO_OUT;
`else
    assign unused_ok = ^{GPIO_OUT, trigger};
`endif
endmodule
